// File: rtl/z_ctrl_pkg.sv
// Shared definitions for the z_ctrl layer controller: FSM state codes,
// index-width helpers, per-neuron BRAM stride and the address term selector.
package z_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BADDR = 3'd1;
  localparam logic [2:0] S_BLOAD = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_FB    = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  // Index width for a counter over 'depth' items; never narrower than 1 bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One bias word followed by the weights of a neuron.
  function automatic int stride(input int iwidth);
    return iwidth + 1;
  endfunction

  localparam int DEF_IWIDTH = 64;
  localparam int DEF_HIDDEN = 16;
  localparam int KW_DEF     = idx_w(DEF_IWIDTH);
  localparam int NW_DEF     = idx_w(DEF_HIDDEN);

  // Which word of the neuron's block is being addressed.
  typedef enum logic [1:0] {
    TERM_BIAS  = 2'd0,
    TERM_FIRST = 2'd1,
    TERM_NEXT  = 2'd2
  } term_e;

endpackage

// File: rtl/z_ctrl_if.sv
// Control bus between the z_ctrl sequencer and the z datapath / BRAM.
// The layer_base input exists only when ZCTRL_LAYER_BASE_EN is defined.
interface z_ctrl_if
  import z_ctrl_pkg::*;
#(
  parameter int AWIDTH = 11,
  parameter int KW     = KW_DEF,
  parameter int NW     = NW_DEF
);
  logic              start;
  logic              z_ready;
`ifdef ZCTRL_LAYER_BASE_EN
  logic [AWIDTH-1:0] layer_base;
`endif
  logic [AWIDTH-1:0] bram_addr;
  logic              bram_en;
  logic [KW-1:0]     k_idx;
  logic              sel;
  logic              enable_out;
  logic              enable_prev;
  logic              z_valid;
  logic [NW-1:0]     z_idx;
  logic              busy;
  logic              done;

  modport master (
`ifdef ZCTRL_LAYER_BASE_EN
    input  layer_base,
`endif
    input  start, z_ready,
    output bram_addr, bram_en, k_idx, sel, enable_out, enable_prev,
    output z_valid, z_idx, busy, done
  );

  modport slave (
`ifdef ZCTRL_LAYER_BASE_EN
    output layer_base,
`endif
    output start, z_ready,
    input  bram_addr, bram_en, k_idx, sel, enable_out, enable_prev,
    input  z_valid, z_idx, busy, done
  );
endinterface

// File: rtl/zctrl_addr_gen.sv
// BRAM address generator: neuron base (n * stride), term offset inside the
// neuron block and layer offset, all unsigned modulo 2^AWIDTH.
module zctrl_addr_gen
  import z_ctrl_pkg::*;
#(
  parameter int AWIDTH = 11,
  parameter int IWIDTH = 64,
  parameter int KW     = idx_w(IWIDTH),
  parameter int NW     = NW_DEF
) (
  input  logic [NW-1:0]     n,
  input  logic [KW-1:0]     i,
  input  term_e             term,
  input  logic [AWIDTH-1:0] layer_off,
  output logic [AWIDTH-1:0] addr
);
  localparam logic [AWIDTH-1:0] STRIDE_A = AWIDTH'(stride(IWIDTH));

  logic [AWIDTH-1:0] base_n;
  logic [AWIDTH-1:0] term_off;

  // Bias sits at the block start, weight 0 right after it, weight i+1 during feedback.
  always_comb begin
    base_n = AWIDTH'(n) * STRIDE_A;
    case (term)
      TERM_BIAS:  term_off = '0;
      TERM_FIRST: term_off = AWIDTH'(1);
      TERM_NEXT:  term_off = AWIDTH'(i) + AWIDTH'(2);
      default:    term_off = '0;
    endcase
    addr = base_n + term_off + layer_off;
  end
endmodule

// File: rtl/z_ctrl.sv
// z_ctrl: sequences one neural layer evaluation -- bias load, multiply-
// accumulate over IWIDTH inputs with out->prev feedback, z handshake per
// neuron. Optional ZCTRL_LAYER_BASE_EN adds a per-layer BRAM offset.
module z_ctrl
  import z_ctrl_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 11,
  parameter int IWIDTH       = 64,
  parameter int HiddenNeuron = 16
) (
  input  logic     clk,
  input  logic     reset,
  z_ctrl_if.master bus
);
  localparam int KW = idx_w(IWIDTH);
  localparam int NW = idx_w(HiddenNeuron);
  localparam logic [KW-1:0] I_LAST = KW'(IWIDTH - 1);
  localparam logic [NW-1:0] N_LAST = NW'(HiddenNeuron - 1);

  if (DWIDTH < 1 || HiddenNeuron * (IWIDTH + 1) > (1 << AWIDTH)) begin : g_param_check
    $error("z_ctrl: illegal parameter combination");
  end

  logic [2:0]        state;
  logic [NW-1:0]     n;
  logic [KW-1:0]     i;
  logic [AWIDTH-1:0] layer_off;
  logic [AWIDTH-1:0] addr;
  logic              addr_en;
  term_e             term;

`ifdef ZCTRL_LAYER_BASE_EN
  // Capture the layer offset on the accepted start so it is stable for the layer.
  always_ff @(posedge clk) begin
    if (reset)
      layer_off <= '0;
    else if (state == S_IDLE && bus.start)
      layer_off <= bus.layer_base;
  end
`else
  assign layer_off = '0;
`endif

  zctrl_addr_gen #(
    .AWIDTH (AWIDTH),
    .IWIDTH (IWIDTH),
    .KW     (KW),
    .NW     (NW)
  ) u_addr_gen (
    .n         (n),
    .i         (i),
    .term      (term),
    .layer_off (layer_off),
    .addr      (addr)
  );

  // Layer FSM with neuron (n) and input (i) counters; start outside IDLE is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      n     <= '0;
      i     <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_BADDR;
          n     <= '0;
          i     <= '0;
        end
        S_BADDR: state <= S_BLOAD;
        S_BLOAD: begin
          i     <= '0;
          state <= S_ACC;
        end
        S_ACC:   state <= (i == I_LAST) ? S_OUT : S_FB;
        S_FB: begin
          i     <= i + KW'(1);
          state <= S_ACC;
        end
        S_OUT: if (bus.z_ready) begin
          if (n == N_LAST) begin
            state <= S_FIN;
          end else begin
            n     <= n + NW'(1);
            state <= S_BADDR;
          end
        end
        S_FIN: begin
          n     <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the control outputs; anything not named in a state stays 0.
  always_comb begin
    addr_en         = 1'b0;
    term            = TERM_BIAS;
    bus.sel         = 1'b0;
    bus.enable_out  = 1'b0;
    bus.enable_prev = 1'b0;
    bus.z_valid     = 1'b0;
    bus.k_idx       = '0;
    bus.z_idx       = '0;
    bus.busy        = (state != S_IDLE);
    bus.done        = 1'b0;
    case (state)
      S_BADDR: addr_en = 1'b1;
      S_BLOAD: begin
        addr_en         = 1'b1;
        term            = TERM_FIRST;
        bus.sel         = 1'b1;
        bus.enable_prev = 1'b1;
      end
      S_ACC: begin
        bus.enable_out = 1'b1;
        bus.k_idx      = i;
      end
      S_FB: begin
        addr_en         = 1'b1;
        term            = TERM_NEXT;
        bus.enable_prev = 1'b1;
      end
      S_OUT: begin
        bus.z_valid = 1'b1;
        bus.z_idx   = n;
      end
      S_FIN:   bus.done = 1'b1;
      default: ;
    endcase
    bus.bram_en   = addr_en;
    bus.bram_addr = addr_en ? addr : '0;
  end
endmodule

// File: tb/tb_z_ctrl.sv
// Bench for z_ctrl with IWIDTH=4, HiddenNeuron=2: drives layers, models the
// z datapath from the control outputs and scoreboards addresses and z values.
module tb_z_ctrl;
  import z_ctrl_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 11;
  localparam int IW  = 4;
  localparam int HN  = 2;
  localparam int KW  = idx_w(IW);
  localparam int NW  = idx_w(HN);
  localparam int PER = 2 * IW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z_ctrl_if #(.AWIDTH(AW), .KW(KW), .NW(NW)) bus ();

  z_ctrl #(
    .DWIDTH       (DW),
    .AWIDTH       (AW),
    .IWIDTH       (IW),
    .HiddenNeuron (HN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic signed [15:0] mem [0:(1<<AW)-1];
  logic signed [15:0] xin [0:IW-1];
  logic [AW-1:0]      lb;
  logic [AW-1:0]      addr_q[$];
  logic [31:0]        z_q[$];

  function automatic logic signed [15:0] qmul(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    return p[23:8];
  endfunction

  function automatic logic [15:0] golden_z(input int nn);
    logic signed [15:0] acc;
    int base;
    base = int'(lb) + nn * (IW + 1);
    acc  = mem[base];
    for (int k = 0; k < IW; k++) acc = acc + qmul(mem[base + 1 + k], xin[k]);
    return acc;
  endfunction

  // z datapath model: BRAM with 1-cycle latency, prev and out registers.
  logic signed [15:0] bram_q, prev_r, out_r;
  always @(posedge clk) begin
    if (bus.bram_en)     bram_q <= mem[bus.bram_addr];
    if (bus.enable_prev) prev_r <= bus.sel ? bram_q : out_r;
    if (bus.enable_out)  out_r  <= prev_r + qmul(bram_q, xin[bus.k_idx]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.bram_addr, bus.bram_en, bus.k_idx, bus.sel, bus.enable_out,
                bus.enable_prev, bus.z_valid, bus.z_idx, bus.busy, bus.done});
  endfunction

  task automatic push_layer();
    for (int nn = 0; nn < HN; nn++) begin
      for (int j = 0; j <= IW; j++) addr_q.push_back(AW'(int'(lb) + nn * (IW + 1) + j));
      z_q.push_back({16'(nn), golden_z(nn)});
    end
  endtask

  // One layer run starting at the current negedge (cycle 0).
  task automatic run_layer(input string nm, input int stall, input int extra_start,
                           input int abort_at);
    int cnt = 0, zv_n = 0, zv0 = -1, zv1 = -1, done_at = -1, done_cnt = 0, stall_t = -1;
    bit fin = 1'b0, prev_zv = 1'b0;
    logic [31:0]   e;
    logic [AW-1:0] ea;
    push_layer();
    bus.z_ready = (stall == 0);
    bus.start   = 1'b1;
    while (!fin && cnt < 400) begin
      @(negedge clk);
      cnt++;
      bus.start = (cnt == extra_start);
`ifdef ZCTRL_LAYER_BASE_EN
      if (cnt == 1) bus.layer_base = lb ^ AW'(11'h100);
`endif
      if (cnt == 1) chk({nm, ":busy_rise"}, bus.busy, 1);
      if (bus.bram_en) begin
        chk({nm, ":addr_avail"}, addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          chk({nm, ":bram_addr"}, bus.bram_addr, ea);
        end
      end
      chk({nm, ":en_excl"}, bus.enable_out & bus.enable_prev, 0);
      if (bus.z_valid) begin
        if (!prev_zv) begin
          if (zv_n == 0) zv0 = cnt; else zv1 = cnt;
        end
        if (stall > 0 && zv_n == 0) begin
          if (stall_t < 0) stall_t = cnt;
          chk({nm, ":stall_zidx"}, bus.z_idx, 0);
          if (cnt == stall_t + stall) bus.z_ready = 1'b1;
        end
        if (bus.z_ready) begin
          chk({nm, ":z_avail"}, z_q.size() != 0, 1);
          if (z_q.size() != 0) begin
            e = z_q.pop_front();
            chk({nm, ":z_idx"}, bus.z_idx, e[31:16]);
            chk({nm, ":z"}, out_r, e[15:0]);
          end
          zv_n++;
        end
      end
      prev_zv = bus.z_valid;
      if (bus.done) begin
        if (done_at < 0) done_at = cnt;
        done_cnt++;
      end
      if (abort_at < 0 && done_at >= 0 && cnt == done_at + 1) begin
        chk({nm, ":done_len"}, bus.done, 0);
        chk({nm, ":busy_fall"}, bus.busy, 0);
        fin = 1'b1;
      end
      if (abort_at >= 0) begin
        if (cnt == abort_at) begin
          reset     = 1'b1;
          bus.start = 1'b1;
        end else if (cnt == abort_at + 1) begin
          reset     = 1'b0;
          bus.start = 1'b0;
          chk({nm, ":abort_outs"}, all_outs(), 0);
        end else if (cnt == abort_at + 6) begin
          chk({nm, ":abort_no_done"}, done_cnt, 0);
          chk({nm, ":abort_idle"}, all_outs(), 0);
          fin = 1'b1;
        end
      end
    end
    bus.start   = 1'b0;
    bus.z_ready = 1'b1;
`ifdef ZCTRL_LAYER_BASE_EN
    bus.layer_base = lb;
`endif
    chk({nm, ":timeout"}, fin, 1);
    if (abort_at < 0) begin
      chk({nm, ":zv0_cycle"}, zv0, PER);
      chk({nm, ":zv1_cycle"}, zv1, 2 * PER + stall);
      chk({nm, ":done_cycle"}, done_at, HN * PER + 1 + stall);
      chk({nm, ":addr_left"}, addr_q.size(), 0);
      chk({nm, ":z_left"}, z_q.size(), 0);
    end else begin
      addr_q.delete();
      z_q.delete();
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.z_ready = 1'b1;
    lb          = '0;
`ifdef ZCTRL_LAYER_BASE_EN
    lb             = AW'(11'h040);
    bus.layer_base = lb;
`endif
    for (int j = 0; j < (1 << AW); j++) mem[j] = 16'sh0100;
    for (int k = 0; k < IW; k++) xin[k] = 16'sh0100;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    @(negedge clk);
    chk("reset_idle", all_outs(), 0);

    run_layer("basic", 0, -1, -1);
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    run_layer("busy_start", 0, 5, -1);

    for (int j = 0; j < (1 << AW); j++) mem[j] = 16'($urandom_range(0, 1023) - 512);
    for (int k = 0; k < IW; k++) xin[k] = 16'($urandom_range(0, 1023) - 512);

    run_layer("stall", 3, -1, -1);
    run_layer("abort", 0, -1, PER + 3);
    run_layer("restart", 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/z_ctrl.md
Z_CTRL -- requirements
Module: z_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DWIDTH, 16, datapath word width.
- AWIDTH, 11, BRAM address width.
- IWIDTH, 64, inputs per neuron.
- HiddenNeuron, 16, neurons per layer.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin layer evaluation.
- z_ready, in, 1, downstream accepts z.
- bram_addr, out, AWIDTH, weight/bias read address.
- bram_en, out, 1, BRAM read enable.
- k_idx, out, clog2(IWIDTH), selects input operand k.
- sel, out, 1, 1 = prev register loads BRAM word; 0 = prev loads out.
- enable_out, out, 1, out-register enable.
- enable_prev, out, 1, prev-register enable.
- z_valid, out, 1, z datapath output is final.
- z_idx, out, clog2(HiddenNeuron), neuron index of z.
- busy, out, 1, layer in progress.
- done, out, 1, one-cycle layer-complete pulse.

Function
REQ-003 BRAM layout SHALL be per neuron n: bias at n*(IWIDTH+1), weight i at n*(IWIDTH+1)+1+i; BRAM read latency 1 cycle.
REQ-004 FSM states SHALL be IDLE, BADDR, BLOAD, ACC, FB, OUT, FIN.
REQ-005 IDLE: start=1 -> BADDR, n=0, busy=1 from next cycle; start while busy SHALL be ignored.
REQ-006 BADDR: bram_addr=base_n, bram_en=1 -> BLOAD.
REQ-007 BLOAD: sel=1, enable_prev=1; bram_addr=base_n+1, bram_en=1; i=0 -> ACC.
REQ-008 ACC: enable_out=1, k_idx=i; i==IWIDTH-1 -> OUT, else -> FB.
REQ-009 FB: sel=0, enable_prev=1; bram_addr=base_n+2+i, bram_en=1; i++ -> ACC.
REQ-010 OUT: z_valid=1, z_idx=n; hold until z_ready=1; on handshake, n==HiddenNeuron-1 -> FIN, else n++ -> BADDR.
REQ-011 FIN: done=1 for exactly one cycle, busy=0 next cycle -> IDLE.
REQ-012 Unlisted control outputs SHALL be 0 in every state; sel SHALL be 0 except in BLOAD.
REQ-013 Cycles per neuron with z_ready tied high SHALL be 2*IWIDTH+2; layer latency start-to-done SHALL be HiddenNeuron*(2*IWIDTH+2)+1.
REQ-014 Address arithmetic SHALL be unsigned and modulo 2^AWIDTH; HiddenNeuron*(IWIDTH+1) <= 2^AWIDTH is a parameter legality rule.
REQ-015 enable_out and enable_prev SHALL never be asserted in the same cycle.

Reset
REQ-016 reset SHALL force IDLE with n=0, i=0 and all outputs 0, including mid-layer; no done pulse SHALL be generated for an aborted layer.
REQ-017 start sampled in the reset cycle SHALL be ignored.

Configuration
REQ-018 With ZCTRL_LAYER_BASE_EN defined, an input layer_base [AWIDTH] SHALL be added to every bram_addr and SHALL be captured on the accepted start; without the macro, the port SHALL be absent and the offset SHALL be 0.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the width constants clog2(IWIDTH) and clog2(HiddenNeuron), and the per-neuron stride IWIDTH+1.
REQ-020 Address generation (base_n, term offset, layer offset) SHALL be one sub-module, zctrl_addr_gen; the FSM and counters SHALL stay in z_ctrl.

Verification
Bench parameters: IWIDTH=4, HiddenNeuron=2.
REQ-021 Single layer, z_ready=1, start at cycle 0 -> bram_addr sequence 0,1,2,3,4 for neuron 0 and 5,6,7,8,9 for neuron 1; z_valid at cycles 10 and 20; done at cycle 21.
REQ-022 Backpressure: z_ready=0 for 3 cycles at the first OUT -> z_valid and z_idx=0 held 3 extra cycles; done delayed by 3 cycles.
REQ-023 start pulsed while busy -> no restart; address sequence unchanged.
REQ-024 reset asserted in neuron 1's ACC -> next cycle IDLE, all outputs 0, no done pulse; new start restarts at bram_addr 0.
REQ-025 Functional: z datapath driven with bias=0x0100, weights=0x0100, inputs k=0x0100 (Q8.8) -> z=0x0500 for each neuron.
REQ-026 ZCTRL_LAYER_BASE_EN with layer_base=0x040 -> first bram_addr is 0x040 and last is 0x049.
